ff_t_counter_ctrl: RTL
======================

// Module: ff_t_counter_ctrl
// PURPOSE
//   Sequencer for a bank of WIDTH negedge T flip-flops with enable. Drives per-bit toggle
//   lines and a shared enable so the bank acts as a modulo-(MAX_VAL+1) up/down counter.
//   Supports parallel load, hold and one-shot run. Reads bank state back on q_fb.
//   The bank sits beside this block and shares clk and clr with it.
// PARAMETERS
//   WIDTH    4   number of T flip-flops in the bank
//   MAX_VAL  9   terminal value; count range 0..MAX_VAL (MAX_VAL <= 2**WIDTH-1)
// PORTS
//   clk        in   1      clock; controller uses posedge, bank toggles on negedge
//   clr        in   1      reset, asynchronous, active-low (same net as bank clr)
//   start      in   1      level; IDLE/HOLD -> RUN
//   stop       in   1      level; RUN -> HOLD
//   dir        in   1      1 = count up, 0 = count down; sampled every RUN cycle
//   oneshot    in   1      1 = return to IDLE after terminal count instead of wrapping on
//   load_req   in   1      request parallel load of load_val
//   load_val   in   WIDTH  value to load; values > MAX_VAL are clamped to MAX_VAL
//   q_fb       in   WIDTH  bank q outputs (current count)
//   t_out      out  WIDTH  toggle inputs to bank, registered
//   ff_enable  out  1      enable to all bank flip-flops, registered
//   busy       out  1      1 in RUN or LOAD
//   tc         out  1      one-cycle pulse in the cycle the wrap toggle is issued
//   state      out  2      00 IDLE, 01 RUN, 10 HOLD, 11 LOAD
// BEHAVIOUR
//   - Reset (clr=0, any time): state=IDLE, t_out=0, ff_enable=0, busy=0, tc=0 immediately.
//     Bank clears via shared clr. Reset mid-RUN or mid-LOAD aborts with no further toggles.
//   - All outputs are registered on posedge clk. q_fb is sampled at posedge; it settled at
//     the previous negedge. Bank applies t_out at the following negedge. Latency: command
//     sampled at posedge N -> q_fb changed after negedge N.
//   - Priority each posedge: load_req > stop > start.
//   - IDLE: ff_enable=0, t_out=0. load_req -> LOAD. start -> RUN.
//   - LOAD (one cycle): t_out = q_fb ^ clamp(load_val), ff_enable=1.
//     Next state is the state held before LOAD. A LOAD entered from RUN resumes RUN.
//   - RUN: ff_enable=1, one count per clock.
//     Up, q_fb<MAX_VAL: t_out[0]=1, t_out[i]=&q_fb[i-1:0].
//     Up, q_fb>=MAX_VAL: t_out=q_fb (wrap to 0), tc=1.
//     Down, q_fb>0: t_out[0]=1, t_out[i]=&~q_fb[i-1:0].
//     Down, q_fb==0: t_out=q_fb^MAX_VAL (wrap to MAX_VAL), tc=1.
//     With oneshot=1 the wrap cycle instead issues t_out=0 with tc=1 (count stays at the
//     terminal value) and next state is IDLE.
//     stop -> HOLD; that cycle issues t_out=0 and ff_enable=0.
//   - HOLD: ff_enable=0, count frozen. start -> RUN. load_req -> LOAD, then back to HOLD.
//   - load_req together with stop or start: load wins; stop/start are evaluated next cycle
//     if still asserted.
//   - dir change mid-RUN takes effect on the next count with no skipped value.
//   - q_fb > MAX_VAL (only reachable by external preset): treated as terminal
//     (wrap up to 0 / down normally).
//   - busy = (state==RUN)||(state==LOAD). tc is never high outside RUN.
// TESTING
//   1 WIDTH=4, MAX_VAL=9: reset, start=1, dir=1 for 12 clocks -> q_fb 1..9,0,1,2;
//     tc high exactly in the 9->0 cycle.
//   2 dir=0 from q=0 -> next q=9 with tc pulse, then 8,7. Flip dir at q=7 -> next q=8.
//   3 In HOLD with q=5, load_req with load_val=3 -> q=3 after one clock, state back to HOLD;
//     load_val=14 -> q=9 (clamp).
//   4 oneshot=1, up from 7 -> q=8,9, then tc pulse, q stays 9, state=IDLE, ff_enable=0.
//   5 Assert clr low mid-RUN at q=6, between edges -> outputs 0 and state=IDLE immediately;
//     after release, no toggles until start.
//   6 load_req+stop same cycle in RUN with load_val=2 -> LOAD then RUN (q=2); stop honoured
//     next cycle -> HOLD at q=2.

Source files
------------

// File: rtl/ff_t_counter_ctrl_if.sv
// Command/status bundle between the counter sequencer and its driver/bank side.
interface ff_t_counter_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             dir;
  logic             oneshot;
  logic             load_req;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] t_out;
  logic             ff_enable;
  logic             busy;
  logic             tc;
  logic [1:0]       state;

  modport master (
    output start, stop, dir, oneshot, load_req, load_val, q_fb,
    input  t_out, ff_enable, busy, tc, state
  );

  modport slave (
    input  start, stop, dir, oneshot, load_req, load_val, q_fb,
    output t_out, ff_enable, busy, tc, state
  );
endinterface

// File: rtl/ff_t_counter_ctrl.sv
// Sequencer turning a bank of negedge T flip-flops into a modulo-(MAX_VAL+1)
// up/down counter with parallel load, hold and one-shot run.
module ff_t_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9
) (
  input  logic                clk,
  input  logic                clr,
  ff_t_counter_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, LOAD = 2'b11} st_e;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  st_e              state_q, state_d, ret_q, ret_d, eff;
  logic [WIDTH-1:0] t_q, t_d;
  logic             en_q, en_d, tc_q, tc_d;
  logic [WIDTH-1:0] up_t, dn_t, ld_val;
  logic             wrap, cnt;

  // Toggle masks: bit i flips when all lower bits are 1 (up) or 0 (down).
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_pre
    assign up_t[i] = up_t[i-1] &  bus.q_fb[i-1];
    assign dn_t[i] = dn_t[i-1] & ~bus.q_fb[i-1];
  end

  assign ld_val = (bus.load_val > MAXV) ? MAXV : bus.load_val;
  assign wrap   = bus.dir ? (bus.q_fb >= MAXV) : (bus.q_fb == '0);

  // LOAD is transparent: commands are judged against the state it interrupted.
  assign eff = (state_q == LOAD) ? ret_q : state_q;
  assign cnt = !bus.load_req && !bus.stop &&
               ((eff == RUN) || (((eff == IDLE) || (eff == HOLD)) && bus.start));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      t_q     <= '0;
      en_q    <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      t_q     <= t_d;
      en_q    <= en_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = eff;
    ret_d   = ret_q;
    if (bus.load_req) begin
      state_d = LOAD;
      ret_d   = eff;
    end else begin
      case (eff)
        IDLE, HOLD: if (!bus.stop && bus.start) state_d = RUN;
        RUN: begin
          if (bus.stop)                             state_d = HOLD;
          // one-shot: tc pulse is issued while still in RUN, IDLE follows
          else if (wrap && bus.oneshot && tc_q)     state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    t_d  = '0;
    en_d = 1'b0;
    tc_d = 1'b0;
    if (bus.load_req) begin
      t_d  = bus.q_fb ^ ld_val;
      en_d = 1'b1;
    end else if (cnt) begin
      en_d = 1'b1;
      if (!wrap) begin
        t_d = bus.dir ? up_t : dn_t;
      end else if (bus.oneshot) begin
        if (eff == RUN && tc_q) en_d = 1'b0;
        else                    tc_d = 1'b1;
      end else begin
        tc_d = 1'b1;
        t_d  = bus.dir ? bus.q_fb : (bus.q_fb ^ MAXV);
      end
    end
  end

  assign bus.t_out     = t_q;
  assign bus.ff_enable = en_q;
  assign bus.tc        = tc_q;
  assign bus.state     = state_q;
  assign bus.busy      = (state_q == RUN) || (state_q == LOAD);
endmodule
